// File: rtl/regfile_sb.sv
// Register file with a per-register busy (scoreboard) bit, reservation port and
// pending-reservation counter; optional write-to-read bypass and hard-wired r0.
module regfile_sb #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_a1,
  input  logic [ADDR_W-1:0] i_a2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  output logic              o_busy1,
  output logic              o_busy2,
  input  logic              i_we3,
  input  logic [ADDR_W-1:0] i_a3,
  input  logic [DATA_W-1:0] i_wd3,
  input  logic              i_rsv_req,
  input  logic [ADDR_W-1:0] i_rsv_a,
  output logic              o_rsv_ok,
  output logic [ADDR_W:0]   o_pend_cnt
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam int unsigned CW   = ADDR_W + 1;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [CW-1:0]     r_pend_cnt;

  logic            w_wr_en;
  logic            w_set_en;
  logic            w_inc;
  logic            w_dec;
  logic [NREG-1:0] w_clr_vec;
  logic [NREG-1:0] w_set_vec;

  assign w_wr_en  = i_we3 && !(ZERO_R0 && (i_a3 == '0));
  assign o_rsv_ok = i_rsv_req && (!r_busy[i_rsv_a] || (i_we3 && (i_a3 == i_rsv_a)));
  // An accepted reservation of a hard-wired r0 sets nothing.
  assign w_set_en = o_rsv_ok && !(ZERO_R0 && (i_rsv_a == '0));

  assign w_clr_vec = w_wr_en  ? (NREG'(1) << i_a3)    : '0;
  assign w_set_vec = w_set_en ? (NREG'(1) << i_rsv_a) : '0;

  // Count only real bit transitions; a set overriding a same-address clear is a no-op.
  assign w_inc = w_set_en && !r_busy[i_rsv_a];
  assign w_dec = w_wr_en && r_busy[i_a3] && !(w_set_en && (i_rsv_a == i_a3));

  always_comb begin
    o_rd1   = r_regs[i_a1];
    o_busy1 = r_busy[i_a1];
    if (BYPASS && w_wr_en && (i_a3 == i_a1)) begin
      o_rd1   = i_wd3;
      o_busy1 = 1'b0;
    end
    if (ZERO_R0 && (i_a1 == '0)) begin
      o_rd1   = '0;
      o_busy1 = 1'b0;
    end
  end

  always_comb begin
    o_rd2   = r_regs[i_a2];
    o_busy2 = r_busy[i_a2];
    if (BYPASS && w_wr_en && (i_a3 == i_a2)) begin
      o_rd2   = i_wd3;
      o_busy2 = 1'b0;
    end
    if (ZERO_R0 && (i_a2 == '0)) begin
      o_rd2   = '0;
      o_busy2 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[i_a3] <= i_wd3;
      end
      r_busy     <= (r_busy & ~w_clr_vec) | w_set_vec;
      r_pend_cnt <= r_pend_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  assign o_pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance share
// all inputs; expected values go through a scoreboard queue before comparison.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2, a3, rsv_a;
  logic        we3, rsv_req;
  logic [31:0] wd3;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy1_a, busy2_a, busy1_b, busy2_b;
  logic        rsv_ok_a, rsv_ok_b;
  logic [5:0]  pend_a, pend_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .i_a1(a1), .i_a2(a2), .o_rd1(rd1_a), .o_rd2(rd2_a),
    .o_busy1(busy1_a), .o_busy2(busy2_a), .i_we3(we3), .i_a3(a3), .i_wd3(wd3),
    .i_rsv_req(rsv_req), .i_rsv_a(rsv_a), .o_rsv_ok(rsv_ok_a), .o_pend_cnt(pend_a)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_R0(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .i_a1(a1), .i_a2(a2), .o_rd1(rd1_b), .o_rd2(rd2_b),
    .o_busy1(busy1_b), .o_busy2(busy2_b), .i_we3(we3), .i_a3(a3), .i_wd3(wd3),
    .i_rsv_req(rsv_req), .i_rsv_a(rsv_a), .o_rsv_ok(rsv_ok_b), .o_pend_cnt(pend_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3     = 1'b0;
    rsv_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; a1 = '0; a2 = '0; a3 = '0; rsv_a = '0;
    we3 = 1'b0; rsv_req = 1'b0; wd3 = '0;
    #3;
    expect_val("reset_pend", 32'd0);        check(32'(pend_a));
    expect_val("reset_rd1", 32'd0);         check(rd1_a);
    expect_val("reset_busy1", 32'd0);       check(32'(busy1_a));
    expect_val("reset_rsv_ok", 32'd0);      check(32'(rsv_ok_a));
    @(negedge clk);
    reset = 1'b1;

    // Plain write then read
    edge_step();
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hDEADBEEF;
    edge_step();
    idle(); a1 = 5'd7;
    #1;
    expect_val("wr7_rd1", 32'hDEADBEEF);    check(rd1_a);
    expect_val("wr7_busy1", 32'd0);         check(32'(busy1_a));

    // Hard-wired r0
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h5;
    edge_step();
    idle(); a1 = 5'd0; rsv_req = 1'b1; rsv_a = 5'd0;
    #1;
    expect_val("r0_rd1", 32'd0);            check(rd1_a);
    expect_val("r0_rsv_ok", 32'd1);         check(32'(rsv_ok_a));
    edge_step();
    idle();
    expect_val("r0_pend", 32'd0);           check(32'(pend_a));
    expect_val("r0_busy1", 32'd0);          check(32'(busy1_a));

    // Reserve 4, reject duplicate, write clears with bypass
    rsv_req = 1'b1; rsv_a = 5'd4;
    #1;
    expect_val("rsv4_ok", 32'd1);           check(32'(rsv_ok_a));
    edge_step();
    a1 = 5'd4;
    #1;
    expect_val("rsv4_pend", 32'd1);         check(32'(pend_a));
    expect_val("rsv4_busy1", 32'd1);        check(32'(busy1_a));
    expect_val("rsv4_dup_ok", 32'd0);       check(32'(rsv_ok_a));
    edge_step();
    expect_val("rsv4_dup_pend", 32'd1);     check(32'(pend_a));
    idle(); we3 = 1'b1; a3 = 5'd4; wd3 = 32'h10;
    #1;
    expect_val("byp4_busy1", 32'd0);        check(32'(busy1_a));
    expect_val("byp4_rd1", 32'h10);         check(rd1_a);
    expect_val("nobyp4_busy1", 32'd1);      check(32'(busy1_b));
    expect_val("nobyp4_rd1", 32'd0);        check(rd1_b);
    edge_step();
    idle();
    expect_val("wr4_pend", 32'd0);          check(32'(pend_a));
    expect_val("wr4_rd1_b", 32'h10);        check(rd1_b);

    // Write and re-reserve the same busy register
    rsv_req = 1'b1; rsv_a = 5'd9;
    edge_step();
    expect_val("rsv9_pend", 32'd1);         check(32'(pend_a));
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h22;
    #1;
    expect_val("wr_rsv9_ok", 32'd1);        check(32'(rsv_ok_a));
    edge_step();
    idle(); a1 = 5'd9;
    #1;
    expect_val("wr_rsv9_pend", 32'd1);      check(32'(pend_a));
    expect_val("wr_rsv9_busy1", 32'd1);     check(32'(busy1_a));
    expect_val("wr_rsv9_rd1", 32'h22);      check(rd1_a);

    // Set and clear on different addresses in one edge
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h23; rsv_req = 1'b1; rsv_a = 5'd6;
    edge_step();
    idle();
    expect_val("swap_pend", 32'd1);         check(32'(pend_a));
    // Write to a non-busy register leaves the count alone
    we3 = 1'b1; a3 = 5'd12; wd3 = 32'h1;
    edge_step();
    idle();
    expect_val("wr_free_pend", 32'd1);      check(32'(pend_a));
    we3 = 1'b1; a3 = 5'd6; wd3 = 32'h2;
    edge_step();
    idle();
    expect_val("clr6_pend", 32'd0);         check(32'(pend_a));

    // Fill every reservable register, then asynchronous reset mid-cycle
    for (int r = 1; r < 32; r++) begin
      rsv_req = 1'b1; rsv_a = 5'(r);
      edge_step();
    end
    idle();
    a1 = 5'd7; a2 = 5'd9;
    #1;
    expect_val("full_pend", 32'd31);        check(32'(pend_a));
    expect_val("full_busy2", 32'd1);        check(32'(busy2_a));
    expect_val("full_rd1", 32'hDEADBEEF);   check(rd1_a);
    #1;
    reset = 1'b0;
    #1;
    expect_val("arst_pend", 32'd0);         check(32'(pend_a));
    expect_val("arst_busy1", 32'd0);        check(32'(busy1_a));
    expect_val("arst_busy2", 32'd0);        check(32'(busy2_a));
    expect_val("arst_rd1", 32'd0);          check(rd1_a);
    expect_val("arst_rd2", 32'd0);          check(rd2_a);

    // Writes and reservations are ignored while reset is held
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h77; rsv_req = 1'b1; rsv_a = 5'd5;
    edge_step();
    idle();
    @(negedge clk);
    reset = 1'b1;
    a1 = 5'd3; a2 = 5'd5;
    #1;
    expect_val("rst_hold_rd1", 32'd0);      check(rd1_a);
    expect_val("rst_hold_busy2", 32'd0);    check(32'(busy2_a));

    // No bypass: old value until after the edge
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'hAB; a2 = 5'd3;
    #1;
    expect_val("nobyp3_rd2_pre", 32'd0);    check(rd2_b);
    expect_val("byp3_rd2_pre", 32'hAB);     check(rd2_a);
    edge_step();
    idle();
    expect_val("nobyp3_rd2_post", 32'hAB);  check(rd2_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
